// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution controller.
// Holds the FSM state encoding (also shown on the debug LEDs) and the
// core phase constants.
package exec_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam logic PH_FETCH = 1'b0;
  localparam logic PH_EXEC  = 1'b1;

endpackage

// File: rtl/req_edge.sv
// 1-bit synchronous rising-edge detector for a level request input.
// Ports:
//   clock   - system clock
//   reset   - synchronous active-low reset; clears the history register
//   req     - level request
//   pulse_c - combinational one-cycle pulse on a 0->1 transition of req
module req_edge (
  input  logic clock,
  input  logic reset,
  input  logic req,
  output logic pulse_c
);

  logic req_q;

  // History of the request from the previous cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req;
    end
  end

  assign pulse_c = req & ~req_q;

endmodule

// File: rtl/exec_ctrl.sv
// Run/halt/single-step/breakpoint controller for the 4-bit uP core.
// Generates the core clock-enable and stops the core only at instruction
// boundaries (phase=fetch), counting retired instructions.
// Ports:
//   clock, reset          - clock and synchronous active-low reset
//   run_req/step_req/halt_req - level requests, rising-edge detected
//   bp_en, bp_addr        - breakpoint enable and address
//   pc, phase             - current core PC and phase (0 fetch, 1 execute)
//   cpu_en                - core clock-enable (combinational)
//   halted                - state is HALTED
//   bp_hit                - sticky: core stopped on a breakpoint
//   ctrl_state            - encoded FSM state
//   instr_cnt             - saturating retired-instruction counter
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned PC_W  = 12,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               halt_req,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc,
  input  logic               phase,
  output logic               cpu_en,
  output logic               halted,
  output logic               bp_hit,
  output logic [STATE_W-1:0] ctrl_state,
  output logic [CNT_W-1:0]   instr_cnt
);

  state_e           state_q, state_d;
  logic             bp_hit_q, bp_hit_d;
  logic             skip_bp_q, skip_bp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_p, step_p, halt_p;
  logic             bp_match;
  logic             en_raw;

  req_edge u_run_edge (
    .clock   (clock),
    .reset   (reset),
    .req     (run_req),
    .pulse_c (run_p)
  );

  req_edge u_step_edge (
    .clock   (clock),
    .reset   (reset),
    .req     (step_req),
    .pulse_c (step_p)
  );

  req_edge u_halt_edge (
    .clock   (clock),
    .reset   (reset),
    .req     (halt_req),
    .pulse_c (halt_p)
  );

  // Breakpoint only at a fetch boundary, suppressed for the first fetch
  // after leaving HALTED so a resume does not re-trigger on the same PC.
  assign bp_match = bp_en & (pc == bp_addr) & (phase == PH_FETCH) & ~skip_bp_q;

  // Next-state, enable and sticky-flag logic.
  always_comb begin
    state_d   = state_q;
    en_raw    = 1'b0;
    bp_hit_d  = bp_hit_q;
    skip_bp_d = skip_bp_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_HALTED: begin
        // Halt outranks step and run, so a halt pulse keeps us here.
        if (halt_p) begin
          state_d = ST_HALTED;
        end else if (step_p) begin
          state_d   = ST_STEP;
          skip_bp_d = 1'b1;
          bp_hit_d  = 1'b0;
        end else if (run_p) begin
          state_d   = ST_RUN;
          skip_bp_d = 1'b1;
          bp_hit_d  = 1'b0;
        end
      end

      ST_RUN: begin
        if (halt_p) begin
          // Mid-instruction halt lets the execute phase finish first.
          if (phase == PH_FETCH) begin
            state_d = ST_HALTED;
          end else begin
            en_raw  = 1'b1;
            state_d = ST_DRAIN;
          end
        end else if (bp_match) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end else begin
          en_raw = 1'b1;
        end
      end

      ST_STEP: begin
        if (halt_p) begin
          if (phase == PH_FETCH) begin
            state_d = ST_HALTED;
          end else begin
            en_raw  = 1'b1;
            state_d = ST_DRAIN;
          end
        end else begin
          en_raw = 1'b1;
          if (phase == PH_EXEC) begin
            state_d = ST_HALTED;
          end
        end
      end

      ST_DRAIN: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d = ST_HALTED;
      end
    endcase

    if (en_raw && (phase == PH_FETCH)) begin
      skip_bp_d = 1'b0;
    end

    if (en_raw && (phase == PH_EXEC) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Core is held while reset is asserted, whatever state it was in.
  assign cpu_en = en_raw & reset;

  // State and status registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_HALTED;
      bp_hit_q  <= 1'b0;
      skip_bp_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bp_hit_q  <= bp_hit_d;
      skip_bp_q <= skip_bp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign halted     = (state_q == ST_HALTED);
  assign bp_hit     = bp_hit_q;
  assign ctrl_state = state_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Testbench for exec_ctrl: directed stimulus with a scoreboard queue and a
// separate negedge monitor. A second instance with a 4-bit counter shares all
// inputs so counter saturation is exercised within a short run.
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;

  localparam int unsigned PC_W  = 12;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SAT_W = 4;

  logic              clock;
  logic              reset;
  logic              run_req, step_req, halt_req;
  logic              bp_en;
  logic [PC_W-1:0]   bp_addr;
  logic [PC_W-1:0]   pc;
  logic              phase;

  logic              cpu_en, halted, bp_hit;
  logic [1:0]        ctrl_state;
  logic [CNT_W-1:0]  instr_cnt;

  logic              s_cpu_en, s_halted, s_bp_hit;
  logic [1:0]        s_ctrl_state;
  logic [SAT_W-1:0]  s_instr_cnt;

  typedef struct packed {
    logic             en;
    logic [1:0]       st;
    logic             bp;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total;
  int    bad;
  int    queued;

  exec_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .run_req    (run_req),
    .step_req   (step_req),
    .halt_req   (halt_req),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .phase      (phase),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .ctrl_state (ctrl_state),
    .instr_cnt  (instr_cnt)
  );

  exec_ctrl #(.PC_W(PC_W), .CNT_W(SAT_W)) u_sat (
    .clock      (clock),
    .reset      (reset),
    .run_req    (run_req),
    .step_req   (step_req),
    .halt_req   (halt_req),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .phase      (phase),
    .cpu_en     (s_cpu_en),
    .halted     (s_halted),
    .bp_hit     (s_bp_hit),
    .ctrl_state (s_ctrl_state),
    .instr_cnt  (s_instr_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic expect_out(input string nm, input logic en, input logic [1:0] st,
                            input logic bp, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.en  = en;
    e.st  = st;
    e.bp  = bp;
    e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    queued++;
  endtask

  // Advance one clock; the tiny core model toggles phase (and bumps pc after
  // execute) only when the enable was high in the cycle just finished.
  task automatic next_cycle();
    logic en_s;
    #1;
    en_s = cpu_en;
    @(posedge clock);
    #1;
    if (en_s) begin
      if (phase == PH_EXEC) pc = pc + PC_W'(1);
      phase = ~phase;
    end
  endtask

  // Monitor: compare every pending expectation against both instances.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      exp_t             e;
      string            nm;
      logic [SAT_W-1:0] sat_exp;
      int               errs;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      sat_exp = (e.cnt > CNT_W'(15)) ? SAT_W'(15) : e.cnt[SAT_W-1:0];
      errs = 0;
      if (cpu_en !== e.en) errs++;
      if (ctrl_state !== e.st) errs++;
      if (bp_hit !== e.bp) errs++;
      if (halted !== (e.st == ST_HALTED)) errs++;
      if (instr_cnt !== e.cnt) errs++;
      if (s_cpu_en !== e.en) errs++;
      if (s_ctrl_state !== e.st) errs++;
      if (s_bp_hit !== e.bp) errs++;
      if (s_halted !== (e.st == ST_HALTED)) errs++;
      if (s_instr_cnt !== sat_exp) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL %s: got en=%b st=%0d bp=%b hl=%b cnt=%h sat(en=%b st=%0d bp=%b hl=%b cnt=%h) want en=%b st=%0d bp=%b hl=%b cnt=%h sat_cnt=%h",
                 nm, cpu_en, ctrl_state, bp_hit, halted, instr_cnt,
                 s_cpu_en, s_ctrl_state, s_bp_hit, s_halted, s_instr_cnt,
                 e.en, e.st, e.bp, (e.st == ST_HALTED), e.cnt, sat_exp);
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    queued   = 0;
    reset    = 1'b0;
    run_req  = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = '0;
    pc       = '0;
    phase    = PH_FETCH;

    // Reset held two edges, then idle.
    @(posedge clock);
    #1;
    expect_out("reset", 1'b0, ST_HALTED, 1'b0, 16'd0);
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_out("idle", 1'b0, ST_HALTED, 1'b0, 16'd0);
      next_cycle();
    end

    // Run, then halt on a fetch boundary.
    run_req = 1'b1;
    expect_out("run_pulse", 1'b0, ST_HALTED, 1'b0, 16'd0);
    next_cycle();
    run_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expect_out("run", 1'b1, ST_RUN, 1'b0, CNT_W'(i / 2));
      next_cycle();
    end
    halt_req = 1'b1;
    expect_out("halt_fetch", 1'b0, ST_RUN, 1'b0, 16'd3);
    next_cycle();
    expect_out("halted_bnd", 1'b0, ST_HALTED, 1'b0, 16'd3);
    next_cycle();
    halt_req = 1'b0;

    // Halt arriving in the execute phase drains through DRAIN.
    run_req = 1'b1;
    expect_out("run_pulse2", 1'b0, ST_HALTED, 1'b0, 16'd3);
    next_cycle();
    run_req = 1'b0;
    expect_out("run_fetch", 1'b1, ST_RUN, 1'b0, 16'd3);
    next_cycle();
    halt_req = 1'b1;
    expect_out("halt_exec", 1'b1, ST_RUN, 1'b0, 16'd3);
    next_cycle();
    halt_req = 1'b0;
    expect_out("drain", 1'b0, ST_DRAIN, 1'b0, 16'd4);
    next_cycle();
    expect_out("halted_drain", 1'b0, ST_HALTED, 1'b0, 16'd4);
    next_cycle();

    // Single step with the request held high for five cycles.
    pc = 12'h005;
    step_req = 1'b1;
    expect_out("step_pulse", 1'b0, ST_HALTED, 1'b0, 16'd4);
    next_cycle();
    expect_out("step_fetch", 1'b1, ST_STEP, 1'b0, 16'd4);
    next_cycle();
    expect_out("step_exec", 1'b1, ST_STEP, 1'b0, 16'd4);
    next_cycle();
    expect_out("step_held", 1'b0, ST_HALTED, 1'b0, 16'd5);
    next_cycle();
    expect_out("step_held", 1'b0, ST_HALTED, 1'b0, 16'd5);
    next_cycle();
    step_req = 1'b0;
    expect_out("step_rel", 1'b0, ST_HALTED, 1'b0, 16'd5);
    next_cycle();

    // Breakpoint at 0x00A starting from pc=0x006.
    bp_en   = 1'b1;
    bp_addr = 12'h00A;
    run_req = 1'b1;
    expect_out("bp_run", 1'b0, ST_HALTED, 1'b0, 16'd5);
    next_cycle();
    run_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_out("to_bp", 1'b1, ST_RUN, 1'b0, CNT_W'(5 + i / 2));
      next_cycle();
    end
    expect_out("bp_stop", 1'b0, ST_RUN, 1'b0, 16'd9);
    next_cycle();
    expect_out("bp_halted", 1'b0, ST_HALTED, 1'b1, 16'd9);
    next_cycle();

    // Resume past the breakpoint; run long enough to saturate the 4-bit copy.
    run_req = 1'b1;
    expect_out("resume_pulse", 1'b0, ST_HALTED, 1'b1, 16'd9);
    next_cycle();
    run_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expect_out("resume", 1'b1, ST_RUN, 1'b0, CNT_W'(9 + i / 2));
      next_cycle();
    end
    halt_req = 1'b1;
    expect_out("halt2", 1'b0, ST_RUN, 1'b0, 16'd17);
    next_cycle();
    halt_req = 1'b0;
    expect_out("halted2", 1'b0, ST_HALTED, 1'b0, 16'd17);
    next_cycle();

    // Simultaneous requests: halt wins, stays halted.
    run_req  = 1'b1;
    step_req = 1'b1;
    halt_req = 1'b1;
    expect_out("prio", 1'b0, ST_HALTED, 1'b0, 16'd17);
    next_cycle();
    run_req  = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
    expect_out("prio_after", 1'b0, ST_HALTED, 1'b0, 16'd17);
    next_cycle();
    expect_out("prio_after2", 1'b0, ST_HALTED, 1'b0, 16'd17);
    next_cycle();

    // Reset asserted in the middle of a step.
    step_req = 1'b1;
    expect_out("step3_pulse", 1'b0, ST_HALTED, 1'b0, 16'd17);
    next_cycle();
    step_req = 1'b0;
    expect_out("step3_fetch", 1'b1, ST_STEP, 1'b0, 16'd17);
    next_cycle();
    reset = 1'b0;
    expect_out("rst_step", 1'b0, ST_STEP, 1'b0, 16'd17);
    next_cycle();
    expect_out("rst_hold", 1'b0, ST_HALTED, 1'b0, 16'd0);
    next_cycle();
    reset = 1'b1;
    expect_out("rst_rel", 1'b0, ST_HALTED, 1'b0, 16'd0);
    next_cycle();

    @(negedge clock);
    #1;
    if (total != queued) begin
      $display("FAIL checked %0d of %0d expectations", total, queued);
      bad++;
    end
    if (bad != 0) begin
      $display("FAIL test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
    end
    $display("PASS test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Run/halt/single-step/breakpoint controller for the 4-bit uP core.
- Produces a single clock-enable, cpu_en. cpu_en gates the PC counter, fetch register, accumulator, flags and phase flip-flop, so the core advances only when cpu_en=1.
- Sits between the board pushbuttons/debug inputs and the core. It counts retired instructions and stops the core only at instruction boundaries.

Parameters:
- PC_W, 12, width of the program counter and breakpoint address.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clock).
- run_req  in  1  request to run; level input, rising edge detected internally.
- step_req  in  1  request to execute one instruction; rising edge detected internally.
- halt_req  in  1  request to halt; rising edge detected internally.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint address.
- pc  in  PC_W  current PC from the core.
- phase  in  1  core phase; 0 = fetch, 1 = execute.
- cpu_en  out  1  core clock-enable (combinational from state/inputs).
- halted  out  1  1 when state is HALTED.
- bp_hit  out  1  sticky flag: core stopped on a breakpoint.
- ctrl_state  out  2  encoded FSM state for debug LEDs.
- instr_cnt  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=HALTED, instr_cnt=0, bp_hit=0, skip_bp=0.
  - Edge-detect history registers are set to 0.
  - cpu_en=0 during and after reset.
  - Reset takes effect from any state, including mid-step or mid-drain.
- Edge detection: a request pulse is req & ~req_q, where req_q is the request registered last cycle. Held levels produce exactly one pulse.
- Simultaneous pulses: priority is halt > step > run.
- Instruction boundary: a cycle with phase=0. One instruction = 2 enabled cycles (phase 0 then phase 1).
- States (ctrl_state encoding: HALTED=0, RUN=1, STEP=2, DRAIN=3).
- HALTED:
  - cpu_en=0.
  - run pulse -> RUN; skip_bp=1.
  - step pulse -> STEP; skip_bp=1.
  - bp_hit is cleared on leaving HALTED.
- RUN:
  - bp_match = bp_en & (pc==bp_addr) & (phase==0) & ~skip_bp.
  - If bp_match: cpu_en=0 that same cycle; next state HALTED; bp_hit<=1.
  - Otherwise cpu_en=1.
  - skip_bp clears after the first enabled phase-0 cycle, so resuming from a breakpoint does not retrigger on the same PC.
  - halt pulse with phase=0 -> HALTED; cpu_en=0 that cycle.
  - halt pulse with phase=1 -> DRAIN; cpu_en=1 that cycle so the execute phase completes.
- STEP:
  - cpu_en=1.
  - Leaves for HALTED after the enabled cycle in which phase=1, i.e. the instruction completes.
  - Step entered while halted with phase=1 (possible only after a reset-free misalignment): completes that execute phase only, 1 cycle.
  - Breakpoints are ignored during STEP.
  - halt pulse in STEP behaves as in RUN.
- DRAIN: cpu_en=0; next state HALTED. Requests are ignored in DRAIN.
- instr_cnt:
  - Increments on every cycle with cpu_en=1 and phase=1.
  - Saturates at all-ones; no wrap.
  - Cleared only by reset.
- halted = (state==HALTED).
- No combinational path from a req input to cpu_en except through the registered edge detector.

Decomposition:
- Shared package (exec_ctrl_pkg):
  - FSM state encoding constants (HALTED/RUN/STEP/DRAIN).
  - Phase constants PH_FETCH=0, PH_EXEC=1.
- One natural sub-module: req_edge. It is a 1-bit synchronous rising-edge detector with the same clock/reset, instantiated 3 times.
- The FSM, breakpoint compare and counter stay in exec_ctrl.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release, no requests for 10 cycles -> cpu_en=0, halted=1, ctrl_state=0, instr_cnt=0.
- Run, then halt at a boundary: pulse run_req; core phase toggles 0,1,0,1...; after 6 enabled cycles pulse halt_req with phase=0 -> cpu_en=0 in that cycle, halted=1 next, instr_cnt=3.
- Halt mid-instruction: same setup but halt_req arrives with phase=1 -> cpu_en=1 that cycle, ctrl_state=3 for 1 cycle, then HALTED; instr_cnt incremented for the drained instruction.
- Single step: from HALTED with pc=0x005, phase=0, hold step_req high for 5 cycles -> exactly 2 enabled cycles, then halted=1; instr_cnt +1; no second step from the held level.
- Breakpoint and resume:
  - bp_en=1, bp_addr=0x00A, run with PC incrementing per instruction -> cpu_en=0 in the cycle pc=0x00A, phase=0; bp_hit=1, halted=1.
  - Pulse run_req -> core proceeds past 0x00A without retrigger; bp_hit=0.
- Priority and saturation:
  - Pulse run_req, step_req and halt_req in the same cycle from HALTED -> remains HALTED.
  - Force instr_cnt near 0xFFFF (run 65537 instructions) -> holds 0xFFFF.
  - Assert reset mid-STEP -> HALTED, instr_cnt=0.
